// File: rtl/dp_sign_exp_stage.sv
// Sign/exponent path of an IEEE-754 double multiplier.
// Stage 1 classifies the operands and adds the biased exponents; stage 2
// removes the bias, resolves the special-value flags and forces the exponent
// for special results. Valid/ready handshake at both ends, one pair per cycle.
module dp_sign_exp_stage #(
    parameter int EXP_W = 11,
    parameter int BIAS  = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic             a_man_zero,
    input  logic             b_man_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [EXP_W+1:0] exp_sum,
    output logic [4:0]       flags
);

    localparam int SW = EXP_W + 2;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [SW-1:0] BIAS_S   = SW'(BIAS);
    localparam logic signed [SW-1:0] OVF_LIM  = SW'((1 << EXP_W) - 2);
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic [SW-1:0]        EXP_NAN  = {2'b00, EXP_ONES};

    // Flag bit positions within {nan, inf, zero, ovf, unf}
    localparam int F_NAN  = 4;
    localparam int F_INF  = 3;
    localparam int F_ZERO = 2;
    localparam int F_OVF  = 1;
    localparam int F_UNF  = 0;

    // Stage 1 state
    logic          s1_vld_q;
    logic          s1_sign_q, s1_sign_d;
    logic [SW-1:0] s1_sum_q,  s1_sum_d;
    logic          s1_nan_q,  s1_nan_d;
    logic          s1_inf_q,  s1_inf_d;
    logic          s1_zero_q, s1_zero_d;

    // Stage 2 state (drives the outputs directly)
    logic          s2_vld_q;
    logic          s2_sign_q,  s2_sign_d;
    logic [SW-1:0] s2_exp_q,   s2_exp_d;
    logic [4:0]    s2_flags_q, s2_flags_d;

    logic          s2_adv;
    logic          a_zero, a_inf, a_nan;
    logic          b_zero, b_inf, b_nan;
    logic signed [SW-1:0] unbiased;

    // Stage 2 moves when empty or when downstream takes its result; stage 1
    // moves when empty or when stage 2 moves, which is exactly in_ready.
    assign s2_adv   = ~s2_vld_q | out_ready;
    assign in_ready = ~s1_vld_q | ~s2_vld_q | out_ready;

    // Operand classification and biased exponent sum (subnormals flush to zero)
    always_comb begin
        a_zero    = (a_exp == '0);
        a_inf     = (a_exp == EXP_ONES) &  a_man_zero;
        a_nan     = (a_exp == EXP_ONES) & ~a_man_zero;
        b_zero    = (b_exp == '0);
        b_inf     = (b_exp == EXP_ONES) &  b_man_zero;
        b_nan     = (b_exp == EXP_ONES) & ~b_man_zero;
        s1_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        s1_inf_d  = a_inf | b_inf;
        s1_zero_d = a_zero | b_zero;
        s1_sign_d = a_sign ^ b_sign;
        s1_sum_d  = {2'b00, a_exp} + {2'b00, b_exp};
    end

    // Stage 1 register: captures the operand pair only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_sum_q  <= '0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
        end else if (in_ready) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_sum_q  <= s1_sum_d;
                s1_nan_q  <= s1_nan_d;
                s1_inf_q  <= s1_inf_d;
                s1_zero_q <= s1_zero_d;
            end
        end
    end

    // Bias removal and flag resolution, nan > inf > zero > ovf > unf
    always_comb begin
        unbiased   = $signed(s1_sum_q) - BIAS_S;
        s2_sign_d  = s1_sign_q;
        s2_exp_d   = unbiased;
        s2_flags_d = '0;
        if (s1_nan_q) begin
            s2_sign_d         = 1'b0;
            s2_exp_d          = EXP_NAN;
            s2_flags_d[F_NAN] = 1'b1;
        end else if (s1_inf_q) begin
            s2_exp_d          = EXP_NAN;
            s2_flags_d[F_INF] = 1'b1;
        end else if (s1_zero_q) begin
            s2_exp_d           = '0;
            s2_flags_d[F_ZERO] = 1'b1;
        end else if (unbiased > OVF_LIM) begin
            s2_flags_d[F_OVF] = 1'b1;
        end else if (unbiased < ONE_S) begin
            s2_flags_d[F_UNF] = 1'b1;
        end
    end

    // Stage 2 register: holds its result while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_flags_q <= '0;
        end else if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_q  <= s2_sign_d;
                s2_exp_q   <= s2_exp_d;
                s2_flags_q <= s2_flags_d;
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign sign      = s2_sign_q;
    assign exp_sum   = s2_exp_q;
    assign flags     = s2_flags_q;

endmodule

// File: tb/tb_dp_sign_exp_stage.sv
// Self-checking bench for dp_sign_exp_stage: directed cases with literal
// expectations plus randomized traffic scored against a queue-based model.
module tb_dp_sign_exp_stage;

    typedef struct packed {
        logic        s;
        logic [12:0] e;
        logic [4:0]  f;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign, b_sign;
    logic [10:0] a_exp, b_exp;
    logic        a_man_zero, b_man_zero;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [12:0] exp_sum;
    logic [4:0]  flags;

    int   asserts  = 0;
    int   failures = 0;
    int   emitted  = 0;
    int   stall_seen = 0;
    res_t expq[$];

    dp_sign_exp_stage #(.EXP_W(11), .BIAS(1023)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_man_zero(a_man_zero), .b_man_zero(b_man_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exp_sum(exp_sum), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Product rules written directly from the IEEE special-value table
    function automatic res_t model(input int as, input int ae, input int am,
                                   input int bs, input int be, input int bm);
        res_t r;
        int   e;
        bit   an, ai, az, bn, bi, bz;
        e  = ae + be - 1023;
        an = (ae == 2047) && (am == 0);
        ai = (ae == 2047) && (am != 0);
        az = (ae == 0);
        bn = (be == 2047) && (bm == 0);
        bi = (be == 2047) && (bm != 0);
        bz = (be == 0);
        r.s = 1'((as ^ bs) & 1);
        r.e = e[12:0];
        r.f = 5'b00000;
        if (an || bn || (ai && bz) || (az && bi)) begin
            r.s = 1'b0; r.e = 13'd2047; r.f = 5'b10000;
        end else if (ai || bi) begin
            r.e = 13'd2047; r.f = 5'b01000;
        end else if (az || bz) begin
            r.e = 13'd0; r.f = 5'b00100;
        end else if (e > 2046) begin
            r.f = 5'b00010;
        end else if (e < 1) begin
            r.f = 5'b00001;
        end
        return r;
    endfunction

    // Per-cycle scoreboard: handshake, in_ready occupancy rule, ordered results
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            chk("in_ready_rule", in_ready, (expq.size() < 2) || out_ready);
            if (!in_ready) stall_seen++;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    chk("sign", sign, expq[0].s);
                    chk("exp_sum", exp_sum, expq[0].e);
                    chk("flags", flags, expq[0].f);
                    chk("flags_onehot", ($countones(flags) <= 1), 1);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        emitted++;
                    end
                end
            end
            if (in_valid && in_ready)
                expq.push_back(model(a_sign, a_exp, a_man_zero, b_sign, b_exp, b_man_zero));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic as, input int ae, input logic am,
                         input logic bs, input int be, input logic bm);
        in_valid   = 1'b1;
        a_sign     = as;  a_exp = ae[10:0]; a_man_zero = am;
        b_sign     = bs;  b_exp = be[10:0]; b_man_zero = bm;
    endtask

    // One pair into an empty pipe; result must appear exactly two edges later
    task automatic send_and_check(input string nm,
                                  input logic as, input int ae, input logic am,
                                  input logic bs, input int be, input logic bm,
                                  input logic es, input int ee, input logic [4:0] ef);
        logic [12:0] e13;
        e13 = ee[12:0];
        out_ready = 1'b1;
        drive(as, ae, am, bs, be, bm);
        tick();
        in_valid = 1'b0;
        chk({nm, "_lat1_valid"}, out_valid, 0);
        tick();
        chk({nm, "_lat2_valid"}, out_valid, 1);
        chk({nm, "_sign"}, sign, es);
        chk({nm, "_exp"}, exp_sum, e13);
        chk({nm, "_flags"}, flags, ef);
        tick();
    endtask

    function automatic int rnd_exp();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 2047;
            2:       return $urandom_range(1, 300);
            3:       return $urandom_range(1700, 2046);
            default: return $urandom_range(0, 2047);
        endcase
    endfunction

    initial begin
        res_t r;
        int   i, cyc, base;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_sign = 0; b_sign = 0; a_exp = 0; b_exp = 0; a_man_zero = 1; b_man_zero = 1;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sign", sign, 0);
        chk("reset_exp", exp_sum, 0);
        chk("reset_flags", flags, 0);
        chk("reset_in_ready", in_ready, 1);
        #11 rst_n = 1'b1;

        // Hand-computed pins for the model itself
        r = model(0, 1023, 1, 1, 1024, 1);
        chk("model_normal", r, {1'b1, 13'd1024, 5'b00000});
        r = model(1, 2047, 1, 0, 0, 1);
        chk("model_nan", r, {1'b0, 13'd2047, 5'b10000});
        r = model(0, 2000, 1, 0, 1100, 1);
        chk("model_ovf", r, {1'b0, 13'd2077, 5'b00010});
        r = model(0, 100, 1, 0, 200, 1);
        chk("model_unf", r, {1'b0, 13'd7469, 5'b00001});

        // Directed cases, first one straight out of reset
        tick();
        send_and_check("normal", 0, 1023, 1, 1, 1024, 1, 1, 1024, 5'b00000);
        send_and_check("nan_infxzero", 1, 2047, 1, 0, 0, 1, 0, 2047, 5'b10000);
        send_and_check("ovf", 0, 2000, 1, 0, 1100, 1, 0, 2077, 5'b00010);
        send_and_check("unf", 0, 100, 1, 0, 200, 1, 0, -723, 5'b00001);
        send_and_check("inf", 1, 2047, 1, 1, 500, 0, 0, 2047, 5'b01000);
        send_and_check("zero", 1, 0, 0, 0, 1500, 1, 1, 0, 5'b00100);
        send_and_check("nan_in", 0, 1023, 1, 0, 2047, 0, 0, 2047, 5'b10000);

        // Eight-pair stream with a three-cycle downstream stall in the middle
        base = emitted; stall_seen = 0; i = 0; cyc = 0;
        while (i < 8 && cyc < 100) begin
            drive(i[0], 900 + 20 * i, 1, 0, 100 + 15 * i, 1);
            out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_all_accepted", i, 8);
        repeat (5) tick();
        chk("stream_emitted", emitted - base, 8);
        chk("stream_in_ready_dropped", stall_seen > 0, 1);
        chk("stream_drained", expq.size(), 0);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 7)
                drive($urandom_range(0, 1), rnd_exp(), $urandom_range(0, 1),
                      $urandom_range(0, 1), rnd_exp(), $urandom_range(0, 1));
            else
                in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        chk("random_drained", expq.size(), 0);

        // Asynchronous reset with two pairs in flight
        drive(0, 1023, 1, 0, 1023, 1);
        tick();
        drive(1, 1100, 1, 0, 1000, 1);
        tick();
        in_valid = 1'b0;
        #2;
        chk("prerst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_sign", sign, 0);
        chk("async_rst_exp", exp_sum, 0);
        chk("async_rst_flags", flags, 0);
        chk("async_rst_in_ready", in_ready, 1);
        #20;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("no_stale_after_rst", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/dp_sign_exp_stage.md
DP_SIGN_EXP_STAGE -- requirements
Module: dp_sign_exp_stage

Interface
REQ-001 The block SHALL have parameter EXP_W, default 11, giving the IEEE-754 double exponent width.
REQ-002 The block SHALL have parameter BIAS, default 1023, giving the exponent bias.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, operand pair present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block accepts the pair this cycle.
REQ-007 The block SHALL have ports a_sign and b_sign, inputs, 1 bit each, operand signs.
REQ-008 The block SHALL have ports a_exp and b_exp, inputs, EXP_W bits each, biased exponents.
REQ-009 The block SHALL have ports a_man_zero and b_man_zero, inputs, 1 bit each, high when the 52-bit fraction is zero.
REQ-010 The block SHALL have port out_valid, output, 1 bit, result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit, downstream mantissa/normalise stage accepts.
REQ-012 The block SHALL have port sign, output, 1 bit, product sign.
REQ-013 The block SHALL have port exp_sum, output, EXP_W+2 bits, two's complement unbiased-corrected exponent sum.
REQ-014 The block SHALL have port flags, output, 5 bits, {nan, inf, zero, ovf, unf}, one-hot or all-zero.

Function
REQ-015 The block SHALL be a 2-stage pipeline (S1 classify/add, S2 bias-subtract/flag) with latency 2 cycles from accepted input to out_valid and throughput 1 pair/cycle.
REQ-016 A transfer SHALL occur on in_valid&in_ready at input and out_valid&out_ready at output.
REQ-017 in_ready SHALL be ~S1_valid | ~S2_valid | out_ready; each stage SHALL load when empty or when the stage downstream of it advances.
REQ-018 While out_valid=1 and out_ready=0, sign, exp_sum, flags SHALL hold stable.
REQ-019 The sign output SHALL equal a_sign XOR b_sign, except it SHALL be 0 when flags.nan=1.
REQ-020 exp_sum SHALL equal a_exp + b_exp - BIAS, computed sign-extended to EXP_W+2 bits without wrap.
REQ-021 Operand classification: exp=0 -> zero (subnormals flushed); exp=all-ones with man_zero=1 -> inf; exp=all-ones with man_zero=0 -> NaN.
REQ-022 Flag priority SHALL be: nan (either NaN, or inf×zero) > inf > zero > ovf (exp_sum > 2^EXP_W-2) > unf (exp_sum < 1).
REQ-023 When nan, inf or zero is set, exp_sum SHALL be forced to all-ones, all-ones and zero respectively (EXP_W LSBs; upper bits 0).
REQ-024 Simultaneous input accept and output drain SHALL lose no data and duplicate no data.
REQ-025 Inputs SHALL be sampled only on accept; changes while in_ready=0 SHALL have no effect.

Reset
REQ-026 When rst_n=0, the block SHALL immediately clear both stage valids, forcing out_valid=0, sign=0, exp_sum=0, flags=0, irrespective of clk.
REQ-027 When rst_n=0, in_ready SHALL be 1 and any in-flight pairs SHALL be discarded.
REQ-028 After rst_n rises, the first accepted pair SHALL appear exactly 2 cycles later.

Verification
REQ-029 The bench SHALL cover: a=(0,1023), b=(1,1024), man_zero both 1 -> sign=1, exp_sum=1024, flags=0, out_valid 2 cycles after accept.
REQ-030 The bench SHALL cover: a_exp=2047, a_man_zero=1, b_exp=0 -> flags=10000 (nan), sign=0, exp_sum=2047.
REQ-031 The bench SHALL cover: a_exp=2000, b_exp=1100 -> exp_sum=2077, flags=00010 (ovf); a_exp=100, b_exp=200 -> exp_sum=-723, flags=00001 (unf).
REQ-032 The bench SHALL cover: a continuous stream of 8 pairs with out_ready held low for 3 cycles mid-stream -> in_ready drops once 2 results are held, all 8 results emitted in order, none lost or duplicated.
REQ-033 The bench SHALL cover: rst_n asserted between clock edges with 2 pairs in flight -> out_valid=0 with no clock edge, and no stale result emerges after release.
